// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Bundles the fetch stage's ROM, decoder-strobe, debug-panel and status
//   signals. The decoder/debug side (master) drives ROM data, bus, strobes
//   and run/step; the fetch stage (slave) drives pc, ir, phase and the
//   retirement outputs.
//   Signals:
//     romData    - ROM byte at address pc
//     dbus       - data bus (jump targets, bus-sourced IR loads)
//     loadBarIR  - active-low IR load from dbus during EXEC
//     doJumpBar  - active-low PC load from dbus during EXEC
//     assertRom  - immediate byte consumed during EXEC
//     run / step - free-run enable / synchronised step button
//     pc, ir, phaseExec, retired, instrCount - fetch stage status
interface fetch_sequencer_if #(
  parameter int PC_WIDTH    = 8,
  parameter int COUNT_WIDTH = 16
);
  logic [7:0]             romData;
  logic [7:0]             dbus;
  logic                   loadBarIR;
  logic                   doJumpBar;
  logic                   assertRom;
  logic                   run;
  logic                   step;
  logic [PC_WIDTH-1:0]    pc;
  logic [7:0]             ir;
  logic                   phaseExec;
  logic                   retired;
  logic [COUNT_WIDTH-1:0] instrCount;

  modport master (
    output romData, dbus, loadBarIR, doJumpBar, assertRom, run, step,
    input  pc, ir, phaseExec, retired, instrCount
  );

  modport slave (
    input  romData, dbus, loadBarIR, doJumpBar, assertRom, run, step,
    output pc, ir, phaseExec, retired, instrCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch stage: owns PC and IR, alternates FETCH/EXEC phases,
//   reacts to decoder jump / IR-load strobes, skips immediates, and offers a
//   run / single-step clock enable plus a retired-instruction counter.
//   Ports:
//     clk      - system clock, rising edge
//     resetBar - synchronous active-low reset
//     bus      - fetch_sequencer_if.slave (ROM, dbus, strobes, run/step in;
//                pc, ir, phaseExec, retired, instrCount out)
module fetch_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int RESET_PC    = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              resetBar,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t                 state, state_next;
  logic [PC_WIDTH-1:0]    pc_reg, pc_next;
  logic [7:0]             ir_reg, ir_next;
  logic                   retire_next;
  logic                   retired_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   step_prev;
  logic                   adv;

  // Truncate or zero-extend the 8-bit bus to the PC width.
  function automatic logic [PC_WIDTH-1:0] bus_to_pc(input logic [7:0] d);
    logic [PC_WIDTH+7:0] wide;
    wide = {{PC_WIDTH{1'b0}}, d};
    return wide[PC_WIDTH-1:0];
  endfunction

  // Rising edge of step gives exactly one cycle of advance in step mode.
  assign adv = bus.run | (bus.step & ~step_prev);

  always_comb begin
    state_next  = state;
    pc_next     = pc_reg;
    ir_next     = ir_reg;
    retire_next = 1'b0;
    if (adv) begin
      case (state)
        FETCH: begin
          ir_next    = bus.romData;
          pc_next    = pc_reg + 1'b1;
          state_next = EXEC;
        end
        EXEC: begin
          retire_next = 1'b1;
          if (!bus.doJumpBar) begin
            pc_next = bus_to_pc(bus.dbus);
          end else if (bus.assertRom) begin
            pc_next = pc_reg + 1'b1;
          end
          // A bus-loaded instruction chains straight into another EXEC.
          if (!bus.loadBarIR) begin
            ir_next    = bus.dbus;
            state_next = EXEC;
          end else begin
            state_next = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetBar) begin
      state       <= FETCH;
      pc_reg      <= PC_WIDTH'(RESET_PC);
      ir_reg      <= 8'h00;
      retired_reg <= 1'b0;
      count_reg   <= '0;
      // Held high so a button pressed through reset does not step.
      step_prev   <= 1'b1;
    end else begin
      state       <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      retired_reg <= retire_next;
      count_reg   <= count_reg + COUNT_WIDTH'(retire_next);
      step_prev   <= bus.step;
    end
  end

  assign bus.pc         = pc_reg;
  assign bus.ir         = ir_reg;
  assign bus.phaseExec  = (state == EXEC);
  assign bus.retired    = retired_reg;
  assign bus.instrCount = count_reg;

endmodule
